// File: rtl/mux4_rr_scanner.sv
// mux4_rr_scanner: round-robin sequencer for a 4:1 MUX4.
// Grants one requesting channel at a time and drives its index onto sel.
// sel is held through HOLD_CYCLES hold cycles plus one sample cycle.
// At the end of the grant, mux_out is captured into that channel's sample bit.
module mux4_rr_scanner #(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    input  logic       mux_out,
    output logic [1:0] sel,
    output logic       sel_valid,
    output logic [3:0] grant,
    output logic [3:0] sample,
    output logic       sample_valid,
    output logic [1:0] sample_ch
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    logic [1:0]       r_state;
    logic [1:0]       r_sel;
    logic [3:0]       r_grant;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_last;
    logic [3:0]       r_sample;
    logic             r_sample_valid;
    logic [1:0]       r_sample_ch;

    logic             w_found;
    logic [1:0]       w_pick;
    logic [1:0]       w_idx;

    // Round-robin search starting one past the last granted channel.
    // The 2-bit add wraps, giving the mod-4 walk.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last;
        w_idx   = r_last;
        for (int unsigned k = 1; k <= 4; k++) begin
            w_idx = r_last + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Grant FSM: issues grants, counts the hold time, and releases the grant after sampling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
            r_last  <= 2'd3;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en && w_found) begin
                        r_sel   <= w_pick;
                        r_grant <= 4'b0001 << w_pick;
                        r_cnt   <= CNT_LOAD;
                        r_state <= ST_HOLD;
                    end else begin
                        r_grant <= '0;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    r_last  <= r_sel;
                    r_grant <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_grant <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Capture path: on the sample exit edge, store mux_out in the granted channel's bit and pulse the valid strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_sample_ch    <= '0;
        end else begin
            r_sample_valid <= 1'b0;
            if (r_state == ST_SAMPLE) begin
                r_sample[r_sel] <= mux_out;
                r_sample_ch     <= r_sel;
                r_sample_valid  <= 1'b1;
            end
        end
    end

    assign sel          = r_sel;
    assign sel_valid    = (r_state == ST_HOLD) || (r_state == ST_SAMPLE);
    assign grant        = r_grant;
    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;
    assign sample_ch    = r_sample_ch;

endmodule

// File: tb/tb_mux4_rr_scanner.sv
// Directed bench for mux4_rr_scanner.
// Instance A (HOLD_CYCLES=1) runs a per-cycle vector table.
// Instance B (HOLD_CYCLES=4) covers hold timing and async reset during HOLD.
module tb_mux4_rr_scanner;

    typedef struct {
        logic       en;
        logic [3:0] req;
        logic [3:0] mux_in;
        logic [3:0] grant;
        logic [1:0] sel;
        logic [3:0] sample;
        logic       sv;
        logic [1:0] ch;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, mux_out_a, sel_valid_a, sv_a;
    logic [3:0] req_a, mux_in_a, grant_a, sample_a;
    logic [1:0] sel_a, ch_a;

    logic       rst_b, en_b, mux_out_b, sel_valid_b, sv_b;
    logic [3:0] req_b, mux_in_b, grant_b, sample_b;
    logic [1:0] sel_b, ch_b;

    // MUX4 models: the out signal follows the selected input.
    assign mux_out_a = mux_in_a[sel_a];
    assign mux_out_b = mux_in_b[sel_b];

    mux4_rr_scanner #(.HOLD_CYCLES(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_a), .en(en_a), .req(req_a), .mux_out(mux_out_a),
        .sel(sel_a), .sel_valid(sel_valid_a), .grant(grant_a), .sample(sample_a),
        .sample_valid(sv_a), .sample_ch(ch_a)
    );

    mux4_rr_scanner #(.HOLD_CYCLES(4), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_b), .en(en_b), .req(req_b), .mux_out(mux_out_b),
        .sel(sel_b), .sel_valid(sel_valid_b), .grant(grant_b), .sample(sample_b),
        .sample_valid(sv_b), .sample_ch(ch_b)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vq[$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic [3:0] r, input logic [3:0] m,
                       input logic [3:0] g, input logic [1:0] s, input logic [3:0] smp,
                       input logic v, input logic [1:0] c);
        vq.push_back('{e, r, m, g, s, smp, v, c});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b0; en_a = 1'b0; req_a = '0; mux_in_a = 4'b1010;
        rst_b = 1'b0; en_b = 1'b0; req_b = '0; mux_in_b = 4'b1111;

        // Each row: en, req, mux_in, then the expected grant, sel, sample, sample_valid and sample_ch after the edge.
        // Full sweep with MUX4 in=1010: grants 0,1,2,3 at 3-cycle spacing.
        add(1, 4'hF, 4'hA, 4'h1, 0, 4'h0, 0, 0);
        add(1, 4'hF, 4'hA, 4'h1, 0, 4'h0, 0, 0);
        add(1, 4'hF, 4'hA, 4'h0, 0, 4'h0, 1, 0);
        add(1, 4'hF, 4'hA, 4'h2, 1, 4'h0, 0, 0);
        add(1, 4'hF, 4'hA, 4'h2, 1, 4'h0, 0, 0);
        add(1, 4'hF, 4'hA, 4'h0, 1, 4'h2, 1, 1);
        add(1, 4'hF, 4'hA, 4'h4, 2, 4'h2, 0, 1);
        add(1, 4'hF, 4'hA, 4'h4, 2, 4'h2, 0, 1);
        add(1, 4'hF, 4'hA, 4'h0, 2, 4'h2, 1, 2);
        add(1, 4'hF, 4'hA, 4'h8, 3, 4'h2, 0, 2);
        add(1, 4'hF, 4'hA, 4'h8, 3, 4'h2, 0, 2);
        add(1, 4'hF, 4'hA, 4'h0, 3, 4'hA, 1, 3);
        add(1, 4'hF, 4'hA, 4'h1, 0, 4'hA, 0, 3);
        add(1, 4'hF, 4'hA, 4'h1, 0, 4'hA, 0, 3);
        add(1, 4'hF, 4'hA, 4'h0, 0, 4'hA, 1, 0);
        add(1, 4'hF, 4'hA, 4'h2, 1, 4'hA, 0, 0);
        add(1, 4'hF, 4'hA, 4'h2, 1, 4'hA, 0, 0);
        add(1, 4'hF, 4'hA, 4'h0, 1, 4'hA, 1, 1);
        // Fairness with last=1 and req=1001: grants 3,0,3; sample bits 1 and 2 stay unchanged.
        add(1, 4'h9, 4'h5, 4'h8, 3, 4'hA, 0, 1);
        add(1, 4'h9, 4'h5, 4'h8, 3, 4'hA, 0, 1);
        add(1, 4'h9, 4'h5, 4'h0, 3, 4'h2, 1, 3);
        add(1, 4'h9, 4'h5, 4'h1, 0, 4'h2, 0, 3);
        add(1, 4'h9, 4'h5, 4'h1, 0, 4'h2, 0, 3);
        add(1, 4'h9, 4'h5, 4'h0, 0, 4'h3, 1, 0);
        add(1, 4'h9, 4'h5, 4'h8, 3, 4'h3, 0, 0);
        add(1, 4'h9, 4'h5, 4'h8, 3, 4'h3, 0, 0);
        add(1, 4'h9, 4'h5, 4'h0, 3, 4'h3, 1, 3);
        // req dropped during HOLD: the grant still completes and sample[2] is captured.
        add(1, 4'h4, 4'h4, 4'h4, 2, 4'h3, 0, 3);
        add(1, 4'h0, 4'h4, 4'h4, 2, 4'h3, 0, 3);
        add(1, 4'h0, 4'h4, 4'h0, 2, 4'h7, 1, 2);
        add(1, 4'h0, 4'h4, 4'h0, 2, 4'h7, 0, 2);
        // en=0 holds off new grants.
        for (int i = 0; i < 10; i++) add(0, 4'hF, 4'h4, 4'h0, 2, 4'h7, 0, 2);
        add(1, 4'hF, 4'h4, 4'h8, 3, 4'h7, 0, 2);
        // en dropped mid-grant: the grant completes, then no new grant is issued.
        add(0, 4'hF, 4'h4, 4'h8, 3, 4'h7, 0, 2);
        add(0, 4'hF, 4'h4, 4'h0, 3, 4'h7, 1, 3);
        add(0, 4'hF, 4'h4, 4'h0, 3, 4'h7, 0, 3);

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst grant", 8'(grant_a), 8'h0);
        chk("rst sel", 8'(sel_a), 8'h0);
        chk("rst sel_valid", 8'(sel_valid_a), 8'h0);
        chk("rst sample", 8'(sample_a), 8'h0);
        chk("rst sample_valid", 8'(sv_a), 8'h0);
        chk("rst sample_ch", 8'(ch_a), 8'h0);
        @(negedge clk);
        rst_a = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            en_a = vq[i].en; req_a = vq[i].req; mux_in_a = vq[i].mux_in;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d grant", i), 8'(grant_a), 8'(vq[i].grant));
            chk($sformatf("row%0d sel", i), 8'(sel_a), 8'(vq[i].sel));
            chk($sformatf("row%0d sel_valid", i), 8'(sel_valid_a), 8'(vq[i].grant != 4'h0));
            chk($sformatf("row%0d sample", i), 8'(sample_a), 8'(vq[i].sample));
            chk($sformatf("row%0d sample_valid", i), 8'(sv_a), 8'(vq[i].sv));
            chk($sformatf("row%0d sample_ch", i), 8'(ch_a), 8'(vq[i].ch));
        end

        // Instance B: four hold cycles, then async reset two cycles into the next HOLD.
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        en_b = 1'b1; req_b = 4'hF;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("B hold%0d grant", i), 8'(grant_b), 8'h1);
            chk($sformatf("B hold%0d sel_valid", i), 8'(sel_valid_b), 8'h1);
            chk($sformatf("B hold%0d sample_valid", i), 8'(sv_b), 8'h0);
        end
        @(posedge clk);
        #1;
        chk("B cap sample_valid", 8'(sv_b), 8'h1);
        chk("B cap sample", 8'(sample_b), 8'h1);
        chk("B cap grant", 8'(grant_b), 8'h0);
        @(posedge clk);
        #1;
        chk("B grant ch1", 8'(grant_b), 8'h2);
        @(posedge clk);
        #2;
        rst_b = 1'b0;
        #1;
        chk("B async grant", 8'(grant_b), 8'h0);
        chk("B async sel", 8'(sel_b), 8'h0);
        chk("B async sel_valid", 8'(sel_valid_b), 8'h0);
        chk("B async sample", 8'(sample_b), 8'h0);
        chk("B async sample_valid", 8'(sv_b), 8'h0);
        chk("B async sample_ch", 8'(ch_b), 8'h0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("B in-reset%0d sample_valid", i), 8'(sv_b), 8'h0);
        end
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        chk("B post-reset grant", 8'(grant_b), 8'h1);
        chk("B post-reset sel", 8'(sel_b), 8'h0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("B post%0d sample_valid", i), 8'(sv_b), 8'h0);
            chk($sformatf("B post%0d sample", i), 8'(sample_b), 8'h0);
        end
        @(posedge clk);
        #1;
        chk("B post cap sample_valid", 8'(sv_b), 8'h1);
        chk("B post cap sample", 8'(sample_b), 8'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
